pin_io_ctrl: RTL and testbench

Parametrised pin and LED interface between a board's pads and the p1v core, replacing ad-hoc per-board tristate/LED wiring. Registers core outputs and direction, synchronises pad inputs into clock_160, applies an optional per-pin glitch filter, and emits per-pin edge pulses. Stretches short cog activity pulses so they are visible on LEDs. Instantiated once per board top level; the top drives each pad as pad_oe ? pad_o : 'z'.

---
 rtl/p1v_io_pkg.sv | 15 +
 rtl/io_glitch_filter.sv | 58 +++++
 rtl/pin_io_ctrl.sv | 65 ++++++
 tb/tb_pin_io_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/p1v_io_pkg.sv
// p1v_io_pkg: shared limits and counter sizing for the p1v pin/LED interface
package p1v_io_pkg;

    localparam int SYNC_STAGES_MIN   = 2;
    localparam int SYNC_STAGES_MAX   = 4;
    localparam int FILTER_CYCLES_MIN = 2;
    localparam int FILTER_CYCLES_MAX = 255;
    localparam int STRETCH_BITS_MIN  = 1;
    localparam int STRETCH_BITS_MAX  = 32;

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_glitch_filter.sv
// io_glitch_filter: one pin's pad synchroniser, optional stability filter and change pulse
module io_glitch_filter
    import p1v_io_pkg::*;
#(
    parameter bit ENABLE        = 1'b0,
    parameter int FILTER_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clock_160,
    input  logic inp_resn,
    input  logic pad_i,
    output logic pin_in,
    output logic pin_change
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            sync       <= '0;
            prev       <= 1'b0;
            pin_change <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], pad_i};
            prev       <= pin_in;
            pin_change <= pin_in ^ prev;
        end
    end

    if (ENABLE) begin : g_filt
        localparam int CW = cnt_width(FILTER_CYCLES + 1);
        logic [CW-1:0] c;
        // any cycle that agrees with the current level restarts the count
        always_ff @(posedge clock_160 or negedge inp_resn) begin
            if (!inp_resn) begin
                c      <= '0;
                pin_in <= 1'b0;
            end else if (s == pin_in) begin
                c      <= '0;
            end else if (c == CW'(FILTER_CYCLES - 1)) begin
                c      <= '0;
                pin_in <= s;
            end else begin
                c      <= c + CW'(1);
            end
        end
    end else begin : g_pass
        always_ff @(posedge clock_160 or negedge inp_resn) begin
            if (!inp_resn) pin_in <= 1'b0;
            else           pin_in <= s;
        end
    end

endmodule

// File: rtl/pin_io_ctrl.sv
// pin_io_ctrl: registered pad drive, synchronised/filtered pad inputs and LED pulse stretching
module pin_io_ctrl
    import p1v_io_pkg::*;
#(
    parameter int                 NUMPINS       = 32,
    parameter int                 NUMLEDS       = 8,
    parameter int                 SYNC_STAGES   = 2,
    parameter logic [NUMPINS-1:0] FILTER_MASK   = '0,
    parameter int                 FILTER_CYCLES = 4,
    parameter int                 STRETCH_BITS  = 20
) (
    input  logic               clock_160,
    input  logic               inp_resn,
    input  logic [NUMPINS-1:0] pin_out,
    input  logic [NUMPINS-1:0] pin_dir,
    output logic [NUMPINS-1:0] pin_in,
    output logic [NUMPINS-1:0] pin_change,
    input  logic [NUMPINS-1:0] pad_i,
    output logic [NUMPINS-1:0] pad_o,
    output logic [NUMPINS-1:0] pad_oe,
    input  logic [NUMLEDS-1:0] led_src,
    output logic [NUMLEDS-1:0] ledg
);

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            pad_o  <= '0;
            pad_oe <= '0;
        end else begin
            pad_o  <= pin_out;
            pad_oe <= pin_dir;
        end
    end

    for (genvar g = 0; g < NUMPINS; g++) begin : g_pin
        io_glitch_filter #(
            .ENABLE        (FILTER_MASK[g]),
            .FILTER_CYCLES (FILTER_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_pin (
            .clock_160  (clock_160),
            .inp_resn   (inp_resn),
            .pad_i      (pad_i[g]),
            .pin_in     (pin_in[g]),
            .pin_change (pin_change[g])
        );
    end

    // a fresh pulse reloads the hold; the LED drops the cycle after it runs out
    for (genvar g = 0; g < NUMLEDS; g++) begin : g_led
        logic [STRETCH_BITS-1:0] cnt;
        logic                    lit;
        always_ff @(posedge clock_160 or negedge inp_resn) begin
            if (!inp_resn) begin
                cnt <= '0;
                lit <= 1'b0;
            end else begin
                cnt <= led_src[g] ? '1 : (cnt != '0) ? cnt - STRETCH_BITS'(1) : cnt;
                lit <= led_src[g] || (cnt != '0);
            end
        end
        assign ledg[g] = lit;
    end

endmodule

// File: tb/tb_pin_io_ctrl.sv
// tb_pin_io_ctrl: cycle-indexed scoreboard bench for pin_io_ctrl
module tb_pin_io_ctrl;

    localparam int PO = 0, OE = 1, PIN = 2, CHG = 3, LED = 4;

    logic        clock_160 = 1'b0;
    logic        inp_resn;
    logic [31:0] pin_out, pin_dir, pin_in, pin_change, pad_i, pad_o, pad_oe;
    logic [7:0]  led_src, ledg;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] mask;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    pin_io_ctrl #(
        .NUMPINS       (32),
        .NUMLEDS       (8),
        .SYNC_STAGES   (2),
        .FILTER_MASK   (32'h0000_0020),
        .FILTER_CYCLES (4),
        .STRETCH_BITS  (4)
    ) dut (
        .clock_160  (clock_160),
        .inp_resn   (inp_resn),
        .pin_out    (pin_out),
        .pin_dir    (pin_dir),
        .pin_in     (pin_in),
        .pin_change (pin_change),
        .pad_i      (pad_i),
        .pad_o      (pad_o),
        .pad_oe     (pad_oe),
        .led_src    (led_src),
        .ledg       (ledg)
    );

    always #5 clock_160 = ~clock_160;

    always @(posedge clock_160) cyc <= cyc + 1;

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            PO:      return pad_o;
            OE:      return pad_oe;
            PIN:     return pin_in;
            CHG:     return pin_change;
            default: return {24'b0, ledg};
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            PO:      return "pad_o";
            OE:      return "pad_oe";
            PIN:     return "pin_in";
            CHG:     return "pin_change";
            default: return "ledg";
        endcase
    endfunction

    task automatic expect_at(input int c, input int s, input logic [31:0] m, input logic [31:0] v);
        exp_t e;
        e.cyc  = c;
        e.sig  = s;
        e.mask = m;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock_160);
        #1;
    endtask

    // monitor: compare every expectation that falls due this cycle
    always @(negedge clock_160) begin
        logic [31:0] a;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                a = sig_val(sb[i].sig) & sb[i].mask;
                checks++;
                if (a !== (sb[i].val & sb[i].mask)) begin
                    errors++;
                    $display("FAIL %s cyc %0d mask %h: got %h expected %h",
                             sig_name(sb[i].sig), cyc, sb[i].mask, a, sb[i].val & sb[i].mask);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        int n;
        pin_dir  = '1;
        pin_out  = '0;
        pad_i    = '0;
        led_src  = '0;
        inp_resn = 1'b0;
        tick(1);
        for (int c = cyc; c < cyc + 2; c++) begin
            expect_at(c, OE, '1, '0);
            expect_at(c, PO, '1, '0);
            expect_at(c, PIN, '1, '0);
            expect_at(c, LED, '1, '0);
        end
        tick(2);
        // reset release
        inp_resn = 1'b1;
        n = cyc;
        expect_at(n, OE, '1, '0);
        expect_at(n + 1, OE, '1, '1);
        expect_at(n + 1, CHG, '1, '0);
        tick(2);
        // output latency
        n = cyc;
        pin_dir = 32'h0000FFFF;
        pin_out = 32'h00005A5A;
        expect_at(n, OE, '1, '1);
        expect_at(n + 1, OE, '1, 32'h0000FFFF);
        expect_at(n + 1, PO, '1, 32'h00005A5A);
        tick(2);
        // unfiltered rise on pin 3
        n = cyc;
        pad_i[3] = 1'b1;
        expect_at(n + 2, PIN, 32'h8, 32'h0);
        expect_at(n + 3, PIN, '1, 32'h8);
        expect_at(n + 3, CHG, 32'h8, 32'h0);
        expect_at(n + 4, CHG, '1, 32'h8);
        expect_at(n + 5, CHG, 32'h8, 32'h0);
        tick(7);
        // single-cycle low on unfiltered pin 3 passes through
        n = cyc;
        expect_at(n + 3, PIN, 32'h8, 32'h0);
        expect_at(n + 4, PIN, 32'h8, 32'h8);
        expect_at(n + 4, CHG, 32'h8, 32'h8);
        expect_at(n + 5, CHG, 32'h8, 32'h8);
        expect_at(n + 6, CHG, 32'h8, 32'h0);
        pad_i[3] = 1'b0;
        tick(1);
        pad_i[3] = 1'b1;
        tick(7);
        // 3-cycle pulse on filtered pin 5 is swallowed
        n = cyc;
        for (int c = n; c <= n + 10; c++) begin
            expect_at(c, PIN, 32'h20, 32'h0);
            expect_at(c, CHG, 32'h20, 32'h0);
        end
        pad_i[5] = 1'b1;
        tick(3);
        pad_i[5] = 1'b0;
        tick(8);
        // 3 high, 1 low, 3 high: the low cycle restarts the count
        n = cyc;
        for (int c = n; c <= n + 12; c++) expect_at(c, PIN, 32'h20, 32'h0);
        pad_i[5] = 1'b1;
        tick(3);
        pad_i[5] = 1'b0;
        tick(1);
        pad_i[5] = 1'b1;
        tick(3);
        pad_i[5] = 1'b0;
        tick(7);
        // 6-cycle pulse propagates 4 cycles after the synchronised rise
        n = cyc;
        expect_at(n + 5, PIN, 32'h20, 32'h0);
        expect_at(n + 6, PIN, 32'h20, 32'h20);
        expect_at(n + 6, CHG, 32'h20, 32'h0);
        expect_at(n + 7, CHG, 32'h20, 32'h20);
        expect_at(n + 8, CHG, 32'h20, 32'h0);
        expect_at(n + 11, PIN, 32'h20, 32'h20);
        expect_at(n + 12, PIN, 32'h20, 32'h0);
        expect_at(n + 13, CHG, 32'h20, 32'h20);
        pad_i[5] = 1'b1;
        tick(6);
        pad_i[5] = 1'b0;
        tick(10);
        // LED stretch: one-cycle pulse holds for 16 cycles
        n = cyc;
        expect_at(n, LED, '1, 32'h0);
        for (int c = n + 1; c <= n + 16; c++) expect_at(c, LED, '1, 32'h1);
        expect_at(n + 17, LED, '1, 32'h0);
        led_src[0] = 1'b1;
        tick(1);
        led_src[0] = 1'b0;
        tick(19);
        // retrigger at count 5 reloads the hold
        n = cyc;
        for (int c = n + 1; c <= n + 27; c++) expect_at(c, LED, '1, 32'h1);
        expect_at(n + 28, LED, '1, 32'h0);
        led_src[0] = 1'b1;
        tick(1);
        led_src[0] = 1'b0;
        tick(10);
        led_src[0] = 1'b1;
        tick(1);
        led_src[0] = 1'b0;
        tick(20);
        // async reset during stretch and pending filter count
        n = cyc;
        expect_at(n + 3, LED, '1, 32'h1);
        expect_at(n + 3, PIN, '1, 32'h8);
        expect_at(n + 4, OE, '1, 32'h0);
        expect_at(n + 4, PO, '1, 32'h0);
        expect_at(n + 4, LED, '1, 32'h0);
        expect_at(n + 4, PIN, '1, 32'h0);
        expect_at(n + 4, CHG, '1, 32'h0);
        expect_at(n + 7, OE, '1, 32'h0000FFFF);
        expect_at(n + 7, PIN, '1, 32'h0);
        expect_at(n + 7, CHG, '1, 32'h0);
        expect_at(n + 7, LED, '1, 32'h0);
        expect_at(n + 8, CHG, '1, 32'h0);
        expect_at(n + 9, PIN, '1, 32'h8);
        expect_at(n + 10, CHG, '1, 32'h8);
        expect_at(n + 12, PIN, '1, 32'h28);
        expect_at(n + 13, CHG, '1, 32'h20);
        led_src[0] = 1'b1;
        pad_i[5]   = 1'b1;
        tick(1);
        led_src[0] = 1'b0;
        tick(3);
        inp_resn = 1'b0;
        tick(2);
        inp_resn = 1'b1;
        tick(10);
        tick(2);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations never compared, required 0", sb.size());
            errors += sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
